// File: rtl/sixteen_bit_serial_subtractor.sv
// Digit-serial 16-bit subtractor: D = A - B - Bi, DIGIT_W bits per clock,
// valid/ready on both sides, optional split into two independent byte subtractions.
module sixteen_bit_serial_subtractor #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic A [0:15],
  input  logic B [0:15],
  input  logic Bi,
  input  logic split16,
  output logic out_valid,
  input  logic out_ready,
  output logic D [0:15],
  output logic Bo,
  output logic Bo_low
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned NDIG    = WORD_W / DIGIT_W;
  localparam int unsigned LOW_DIG = 8 / DIGIT_W;
  localparam int unsigned CNT_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned DIFF_W  = DIGIT_W + 1;
  localparam int unsigned RES_W   = WORD_W - DIGIT_W;

  if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 || DIGIT_W == 8)) begin : g_bad_digit_w
    $error("DIGIT_W must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 in_ready_d;
  logic                 out_valid_d;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [WORD_W-1:0]    a_in;
  logic [WORD_W-1:0]    b_in;
  logic [WORD_W-1:0]    a_q;
  logic [WORD_W-1:0]    b_q;
  logic [RES_W-1:0]     res_q;
  logic [WORD_W-1:0]    d_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 borrow_q;
  logic                 split_q;
  logic                 low_borrow_q;
  logic                 bo_q;
  logic                 bo_low_q;

  logic                 accept_c;
  logic                 last_dig_c;
  logic                 low_dig_c;
  logic                 borrow_nxt_c;
  logic [DIFF_W-1:0]    diff_c;
  logic [WORD_W-1:0]    res_nxt_c;

  // Port arrays use element 0 as the LSB; map them onto numeric vectors.
  for (genvar i = 0; i < WORD_W; i++) begin : g_bits
    assign a_in[i] = A[i];
    assign b_in[i] = B[i];
    assign D[i]    = d_q[i];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Bo        = bo_q;
  assign Bo_low    = bo_low_q;

  // One digit of the borrow chain; the extra top bit is the borrow out.
  assign diff_c       = {1'b0, a_q[DIGIT_W-1:0]} - {1'b0, b_q[DIGIT_W-1:0]} - DIFF_W'(borrow_q);
  assign borrow_nxt_c = diff_c[DIGIT_W];
  assign res_nxt_c    = {diff_c[DIGIT_W-1:0], res_q};
  assign accept_c     = (state_q == S_IDLE) && in_valid;
  assign last_dig_c   = (cnt_q == CNT_W'(NDIG - 1));
  assign low_dig_c    = (cnt_q == CNT_W'(LOW_DIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = accept_c ? S_CALC : S_IDLE;
      S_CALC:  state_d = last_dig_c ? S_HOLD : S_CALC;
      S_HOLD:  state_d = out_ready ? S_IDLE : S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      S_IDLE:  in_ready_d  = 1'b1;
      S_HOLD:  out_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand shift registers, borrow chain and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      d_q          <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      split_q      <= 1'b0;
      low_borrow_q <= 1'b0;
      bo_q         <= 1'b0;
      bo_low_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            a_q      <= a_in;
            b_q      <= b_in;
            borrow_q <= Bi;
            split_q  <= split16;
            cnt_q    <= '0;
          end
        end
        S_CALC: begin
          a_q      <= a_q >> DIGIT_W;
          b_q      <= b_q >> DIGIT_W;
          res_q    <= res_nxt_c[WORD_W-1:DIGIT_W];
          cnt_q    <= cnt_q + CNT_W'(1);
          borrow_q <= (low_dig_c && split_q) ? 1'b0 : borrow_nxt_c;
          if (low_dig_c) begin
            low_borrow_q <= borrow_nxt_c;
          end
          if (last_dig_c) begin
            d_q      <= res_nxt_c;
            bo_q     <= borrow_nxt_c;
            bo_low_q <= low_borrow_q;
            cnt_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sixteen_bit_serial_subtractor.sv
// Self-checking bench: three instances (DIGIT_W = 4, 1, 8), directed vector table,
// backpressure and mid-operation reset sequences, then randomised ops against an arithmetic model.
module tb_sixteen_bit_serial_subtractor;

  localparam int NI = 3;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        bl;
  } res_t;

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic        sp;
    int          stall;
    logic [15:0] d;
    logic        bo;
    logic        bl;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0] in_valid_s, in_ready_s, bi_s, split_s, out_valid_s, out_ready_s, bo_s, bo_low_s;
  logic [15:0]   a_s [NI];
  logic [15:0]   b_s [NI];
  logic [15:0]   d_s [NI];
  logic [15:0]   prev_d [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned DW = (g == 0) ? 4 : (g == 1) ? 1 : 8;
    logic a_u [0:15];
    logic b_u [0:15];
    logic d_u [0:15];
    for (genvar i = 0; i < 16; i++) begin : g_map
      assign a_u[i]    = a_s[g][i];
      assign b_u[i]    = b_s[g][i];
      assign d_s[g][i] = d_u[i];
    end
    sixteen_bit_serial_subtractor #(.DIGIT_W(DW)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_s[g]),
      .in_ready (in_ready_s[g]),
      .A        (a_u),
      .B        (b_u),
      .Bi       (bi_s[g]),
      .split16  (split_s[g]),
      .out_valid(out_valid_s[g]),
      .out_ready(out_ready_s[g]),
      .D        (d_u),
      .Bo       (bo_s[g]),
      .Bo_low   (bo_low_s[g])
    );
  end

  function automatic int ndig_of(input int idx);
    return (idx == 0) ? 4 : (idx == 1) ? 16 : 2;
  endfunction

  // Reference: plain signed integer arithmetic on the operand values.
  function automatic res_t ref_sub(input logic [15:0] a, input logic [15:0] b,
                                   input logic bi, input logic sp);
    res_t r;
    int lo;
    int hi;
    int full;
    lo = int'(a[7:0]) - int'(b[7:0]) - int'(bi);
    r.bl = (lo < 0);
    if (sp) begin
      hi = int'(a[15:8]) - int'(b[15:8]);
      r.d  = {8'(hi), 8'(lo)};
      r.bo = (hi < 0);
    end else begin
      full = int'(a) - int'(b) - int'(bi);
      r.d  = 16'(full);
      r.bo = (full < 0);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic scramble(input int idx);
    a_s[idx]        = 16'($urandom);
    b_s[idx]        = 16'($urandom);
    bi_s[idx]       = 1'($urandom);
    split_s[idx]    = 1'($urandom);
    in_valid_s[idx] = 1'($urandom);
  endtask

  // One full operation on instance idx, with stall cycles of out_ready=0 once out_valid is up.
  task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic bi, input logic sp, input int stall,
                        input logic [15:0] ed, input logic eb, input logic ebl);
    int lat;
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready_s[idx]), 32'd1);
    a_s[idx]         = a;
    b_s[idx]         = b;
    bi_s[idx]        = bi;
    split_s[idx]     = sp;
    in_valid_s[idx]  = 1'b1;
    out_ready_s[idx] = (stall == 0);
    @(negedge clk);
    scramble(idx);
    check("in_ready_in_calc", 32'(in_ready_s[idx]), 32'd0);
    check("d_holds_prev", 32'(d_s[idx]), 32'(prev_d[idx]));
    lat = 0;
    while (!out_valid_s[idx] && lat < 40) begin
      @(negedge clk);
      lat++;
      scramble(idx);
    end
    check("latency", 32'(lat), 32'(ndig_of(idx)));
    check("d", 32'(d_s[idx]), 32'(ed));
    check("bo", 32'(bo_s[idx]), 32'(eb));
    check("bo_low", 32'(bo_low_s[idx]), 32'(ebl));
    for (int s = 0; s < stall; s++) begin
      scramble(idx);
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid_s[idx]), 32'd1);
      check("stall_in_ready", 32'(in_ready_s[idx]), 32'd0);
      check("stall_d", 32'(d_s[idx]), 32'(ed));
      check("stall_bo", 32'(bo_s[idx]), 32'(eb));
    end
    in_valid_s[idx]  = 1'b0;
    out_ready_s[idx] = 1'b1;
    @(negedge clk);
    check("out_valid_after_xfer", 32'(out_valid_s[idx]), 32'd0);
    check("in_ready_after_xfer", 32'(in_ready_s[idx]), 32'd1);
    check("d_after_xfer", 32'({bo_s[idx], bo_low_s[idx], d_s[idx]}), 32'({eb, ebl, ed}));
    prev_d[idx] = ed;
  endtask

  vec_t vecs [10];

  initial begin
    res_t r;
    logic [15:0] ra, rb;
    logic rbi, rsp;
    logic ov_seen;
    int idx;

    vecs[0] = '{0, 16'h1234, 16'h0034, 1'b0, 1'b0, 0,  16'h1200, 1'b0, 1'b0};
    vecs[1] = '{0, 16'h0000, 16'h0001, 1'b0, 1'b0, 0,  16'hFFFF, 1'b1, 1'b1};
    vecs[2] = '{0, 16'h0000, 16'h0001, 1'b0, 1'b1, 0,  16'h00FF, 1'b0, 1'b1};
    vecs[3] = '{0, 16'h0100, 16'h0000, 1'b1, 1'b0, 0,  16'h00FF, 1'b0, 1'b1};
    vecs[4] = '{0, 16'h0100, 16'h0000, 1'b1, 1'b1, 0,  16'h01FF, 1'b0, 1'b1};
    vecs[5] = '{0, 16'h8000, 16'h0001, 1'b0, 1'b0, 10, 16'h7FFF, 1'b0, 1'b1};
    vecs[6] = '{1, 16'h0000, 16'h0001, 1'b0, 1'b0, 0,  16'hFFFF, 1'b1, 1'b1};
    vecs[7] = '{1, 16'h0000, 16'h0001, 1'b0, 1'b1, 2,  16'h00FF, 1'b0, 1'b1};
    vecs[8] = '{2, 16'h0000, 16'h0001, 1'b0, 1'b0, 0,  16'hFFFF, 1'b1, 1'b1};
    vecs[9] = '{2, 16'h0000, 16'h0001, 1'b0, 1'b1, 1,  16'h00FF, 1'b0, 1'b1};

    rst_n       = 1'b0;
    in_valid_s  = '0;
    out_ready_s = '1;
    bi_s        = '0;
    split_s     = '0;
    for (int i = 0; i < NI; i++) begin
      a_s[i]    = '0;
      b_s[i]    = '0;
      prev_d[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset_in_ready", 32'(in_ready_s[i]), 32'd1);
      check("reset_out_valid", 32'(out_valid_s[i]), 32'd0);
      check("reset_outputs", 32'({bo_s[i], bo_low_s[i], d_s[i]}), 32'd0);
    end
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].bi, vecs[v].sp, vecs[v].stall,
             vecs[v].d, vecs[v].bo, vecs[v].bl);
    end

    // Reset pulse while instance 0 is partway through CALC.
    @(negedge clk);
    a_s[0] = 16'h1234; b_s[0] = 16'h0034; bi_s[0] = 1'b0; split_s[0] = 1'b0;
    in_valid_s[0] = 1'b1;
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid_s[0]), 32'd0);
    check("midreset_in_ready", 32'(in_ready_s[0]), 32'd1);
    check("midreset_outputs", 32'({bo_s[0], bo_low_s[0], d_s[0]}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) prev_d[i] = '0;
    ov_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      ov_seen = ov_seen | out_valid_s[0];
    end
    check("midreset_no_result", 32'(ov_seen), 32'd0);
    run_op(0, 16'h00FF, 16'h00FE, 1'b0, 1'b0, 0, 16'h0001, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      idx = n % NI;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rbi = 1'($urandom);
      rsp = 1'($urandom);
      r   = ref_sub(ra, rb, rbi, rsp);
      run_op(idx, ra, rb, rbi, rsp, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
             r.d, r.bo, r.bl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
